bf_exec_core: RTL and testbench
===============================

// Module: bf_exec_core
// PURPOSE
//  Brainfuck fetch/execute controller. It is the initiator side of the shared 8-bit
//  program/data sram: drives instptr/dataptr/memwrite/datain and consumes registered
//  instr/data (one-cycle read latency; a write is visible on data the same edge).
//  Executes + - > < . , [ ] with valid/ready byte streams for I/O; 0x00 halts.
// PARAMETERS
//  START_ADDR  8'h00  ip reset value (first instruction address)
//  DATA_BASE   8'h80  sram address of data cell 0; dataptr = (DATA_BASE + dp) mod 256
//  DEPTH_W     8      bracket-scan depth counter width
// PORTS
//  clk       in   1  clock, all state changes on posedge
//  reset     in   1  synchronous, active-high
//  instr     in   8  sram instruction output (mem[instptr] from previous edge)
//  data      in   8  sram data output (mem[dataptr] from previous edge)
//  instptr   out  8  instruction address = ip register
//  dataptr   out  8  data address = DATA_BASE + dp
//  memwrite  out  1  sram write enable, registered
//  datain    out  8  sram write data, registered
//  out_data  out  8  '.' output byte
//  out_valid out  1  out_data valid; held until out_ready
//  out_ready in   1  sink accepts out_data
//  in_data   in   8  ',' input byte
//  in_valid  in   1  in_data valid
//  in_ready  out  1  core waiting for an input byte
//  halted    out  1  core stopped (0x00 fetched or error)
//  error     out  1  unmatched bracket detected; valid when halted
// BEHAVIOUR
//  Reset: ip=START_ADDR, dp=0, depth=0, memwrite=0, datain=0, out_data=0, out_valid=0,
//   in_ready=0, halted=0, error=0, state=FETCH. Reset mid-operation aborts any state,
//   incl. pending writes: memwrite low after the reset edge.
//  States: FETCH, EXEC, WRITE, OUT, IN, SFETCH, SCAN, HALT.
//  FETCH: ip/dp held one cycle so the sram registers mem[ip], mem[DATA_BASE+dp] -> EXEC.
//  EXEC (instr/data valid), by instr:
//   0x2B '+' / 0x2D '-': datain<=data+/-1 (mod 256), memwrite<=1 -> WRITE
//   0x3E '>' / 0x3C '<': dp<=dp+/-1 (mod 256), ip<=ip+1 -> FETCH
//   0x2E '.': out_data<=data, out_valid<=1 -> OUT
//   0x2C ',': in_ready<=1 -> IN
//   0x5B '[': data==0: depth<=1, dir=fwd, ip<=ip+1 -> SFETCH; else ip<=ip+1 -> FETCH
//   0x5D ']': data!=0: depth<=1, dir=back, ip<=ip-1 -> SFETCH; else ip<=ip+1 -> FETCH
//   0x00: halted<=1 -> HALT;  any other byte: no-op, ip<=ip+1 -> FETCH
//  WRITE: memwrite=1 exactly one cycle, then memwrite<=0, ip<=ip+1 -> FETCH.
//  OUT: out_valid, out_data stable until out_valid&&out_ready at an edge; then
//   out_valid<=0, ip<=ip+1 -> FETCH. ip/dp frozen while waiting.
//  IN: on in_valid&&in_ready edge: in_ready<=0, datain<=in_data, memwrite<=1 -> WRITE.
//  SFETCH: one wait cycle -> SCAN. SCAN examines instr:
//   fwd: '[' depth+1, ']' depth-1; back: ']' depth+1, '[' depth-1; others unchanged.
//   depth reaching 0: ip<=ip+1 (just past matching bracket) -> FETCH.
//   else ip<=ip+/-1 -> SFETCH. Depth counter saturating at max => error.
//   0x00 during scan, or back scan at ip==0 without match: error<=1, halted<=1 -> HALT.
//  HALT: all strobes low, outputs frozen, stays until reset.
//  Costs: plain op 2 cycles, +/-/, 3 (plus I/O wait), scan 2 cycles per byte passed.
//  ip wraps 8'hFF->8'h00 in fwd execution. dp wrap may alias program
//   bytes; no protection.
// TESTING
//  1 prog "+++.",0x00 at 0, cell0=0: out_valid first high cycle 11 after reset, out_data=0x03,
//    one transfer; halted=1, error=0 after.
//  2 same prog, out_ready low 10 cycles: out_valid/out_data 0x03 held, instptr stays 3, then one transfer.
//  3 ",+.": in_valid delayed 5 cycles, in_data=0x41 -> in_ready held, single write, out 0x42.
//  4 "++[>+<-]>." -> cell0=0, cell1=2, out 0x02; "[[+]]." with cell0=0 -> nested skip, out 0x00.
//  5 "-<." from dp=0: cell0=0xFF, dataptr=DATA_BASE+0xFF=0x7F, memwrite exactly 1 cycle.
//  6 "[+",0x00 cell0=0 -> halted=1 error=1; reset during SCAN -> instptr=START_ADDR, memwrite=0 next cycle.

Source files
------------

// File: rtl/bf_exec_core_if.sv
// Bus between the Brainfuck core and its environment: the shared program/data
// sram port plus the valid/ready byte streams for '.' and ','.
interface bf_exec_core_if;
  logic [7:0] instr;
  logic [7:0] data;
  logic [7:0] instptr;
  logic [7:0] dataptr;
  logic       memwrite;
  logic [7:0] datain;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       halted;
  logic       error;

  modport master (
    input  instr, data, out_ready, in_data, in_valid,
    output instptr, dataptr, memwrite, datain, out_data, out_valid, in_ready,
           halted, error
  );

  modport slave (
    output instr, data, out_ready, in_data, in_valid,
    input  instptr, dataptr, memwrite, datain, out_data, out_valid, in_ready,
           halted, error
  );
endinterface

// File: rtl/bf_exec_core.sv
// Brainfuck fetch/execute controller driving a shared sram with one-cycle read
// latency; bracket matching is done by stepping ip and counting nesting depth.
module bf_exec_core #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] DATA_BASE  = 8'h80,
  parameter int         DEPTH_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  bf_exec_core_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_WRITE, S_OUT, S_IN, S_SFETCH, S_SCAN, S_HALT
  } state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  state_t             state, state_n;
  logic [7:0]         ip, ip_n;
  logic [7:0]         dp, dp_n;
  logic [DEPTH_W-1:0] depth, depth_n;
  logic               dir_back, dir_back_n;
  logic               memwrite_q, memwrite_n;
  logic [7:0]         datain_q, datain_n;
  logic [7:0]         out_data_q, out_data_n;
  logic               out_valid_q, out_valid_n;
  logic               in_ready_q, in_ready_n;
  logic               halted_q, halted_n;
  logic               error_q, error_n;

  logic               scan_open, scan_close;

  assign bus.instptr   = ip;
  assign bus.dataptr   = DATA_BASE + dp;
  assign bus.memwrite  = memwrite_q;
  assign bus.datain    = datain_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.halted    = halted_q;
  assign bus.error     = error_q;

  // Opening/closing bracket relative to the scan direction
  assign scan_open  = dir_back ? (bus.instr == 8'h5D) : (bus.instr == 8'h5B);
  assign scan_close = dir_back ? (bus.instr == 8'h5B) : (bus.instr == 8'h5D);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      ip          <= START_ADDR;
      dp          <= 8'h00;
      depth       <= '0;
      dir_back    <= 1'b0;
      memwrite_q  <= 1'b0;
      datain_q    <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state       <= state_n;
      ip          <= ip_n;
      dp          <= dp_n;
      depth       <= depth_n;
      dir_back    <= dir_back_n;
      memwrite_q  <= memwrite_n;
      datain_q    <= datain_n;
      out_data_q  <= out_data_n;
      out_valid_q <= out_valid_n;
      in_ready_q  <= in_ready_n;
      halted_q    <= halted_n;
      error_q     <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    ip_n        = ip;
    dp_n        = dp;
    depth_n     = depth;
    dir_back_n  = dir_back;
    memwrite_n  = 1'b0;
    datain_n    = datain_q;
    out_data_n  = out_data_q;
    out_valid_n = out_valid_q;
    in_ready_n  = in_ready_q;
    halted_n    = halted_q;
    error_n     = error_q;

    case (state)
      S_FETCH: state_n = S_EXEC;

      S_EXEC: begin
        case (bus.instr)
          8'h2B: begin
            datain_n   = bus.data + 8'd1;
            memwrite_n = 1'b1;
            state_n    = S_WRITE;
          end
          8'h2D: begin
            datain_n   = bus.data - 8'd1;
            memwrite_n = 1'b1;
            state_n    = S_WRITE;
          end
          8'h3E: begin
            dp_n    = dp + 8'd1;
            ip_n    = ip + 8'd1;
            state_n = S_FETCH;
          end
          8'h3C: begin
            dp_n    = dp - 8'd1;
            ip_n    = ip + 8'd1;
            state_n = S_FETCH;
          end
          8'h2E: begin
            out_data_n  = bus.data;
            out_valid_n = 1'b1;
            state_n     = S_OUT;
          end
          8'h2C: begin
            in_ready_n = 1'b1;
            state_n    = S_IN;
          end
          8'h5B: begin
            ip_n = ip + 8'd1;
            if (bus.data == 8'h00) begin
              depth_n    = DEPTH_ONE;
              dir_back_n = 1'b0;
              state_n    = S_SFETCH;
            end else begin
              state_n = S_FETCH;
            end
          end
          8'h5D: begin
            if (bus.data != 8'h00) begin
              depth_n    = DEPTH_ONE;
              dir_back_n = 1'b1;
              ip_n       = ip - 8'd1;
              state_n    = S_SFETCH;
            end else begin
              ip_n    = ip + 8'd1;
              state_n = S_FETCH;
            end
          end
          8'h00: begin
            halted_n = 1'b1;
            state_n  = S_HALT;
          end
          default: begin
            ip_n    = ip + 8'd1;
            state_n = S_FETCH;
          end
        endcase
      end

      S_WRITE: begin
        ip_n    = ip + 8'd1;
        state_n = S_FETCH;
      end

      S_OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_n = 1'b0;
          ip_n        = ip + 8'd1;
          state_n     = S_FETCH;
        end
      end

      S_IN: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_n = 1'b0;
          datain_n   = bus.in_data;
          memwrite_n = 1'b1;
          state_n    = S_WRITE;
        end
      end

      S_SFETCH: state_n = S_SCAN;

      // A match lands just past the bracket; otherwise keep stepping, failing on
      // a program terminator, depth overflow or running off the start backwards.
      S_SCAN: begin
        if (bus.instr == 8'h00 || (scan_open && depth == DEPTH_MAX)) begin
          error_n  = 1'b1;
          halted_n = 1'b1;
          state_n  = S_HALT;
        end else if (scan_close && depth == DEPTH_ONE) begin
          depth_n = '0;
          ip_n    = ip + 8'd1;
          state_n = S_FETCH;
        end else begin
          if (scan_open) begin
            depth_n = depth + DEPTH_ONE;
          end else if (scan_close) begin
            depth_n = depth - DEPTH_ONE;
          end
          if (dir_back && ip == 8'h00) begin
            error_n  = 1'b1;
            halted_n = 1'b1;
            state_n  = S_HALT;
          end else begin
            ip_n    = dir_back ? ip - 8'd1 : ip + 8'd1;
            state_n = S_SFETCH;
          end
        end
      end

      S_HALT: state_n = S_HALT;

      default: state_n = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_bf_exec_core.sv
// Self-checking bench for bf_exec_core: a behavioural sram plus a scoreboard of
// expected '.' output bytes compared whenever a stream transfer is seen.
module tb_bf_exec_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bf_exec_core_if bus();

  bf_exec_core #(
    .START_ADDR(8'h00),
    .DATA_BASE (8'h80),
    .DEPTH_W   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;
  int xfers = 0;
  int writes = 0;

  // Registered sram: write-first on the data port, old value on the instr port
  always @(posedge clk) begin
    if (bus.memwrite) mem[bus.dataptr] <= bus.datain;
    bus.instr <= mem[bus.instptr];
    bus.data  <= bus.memwrite ? bus.datain : mem[bus.dataptr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs only change just after posedge, so a negedge view predicts the edge
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.memwrite) writes++;
      if (bus.out_valid && bus.out_ready) begin
        xfers++;
        if (exp_q.size() == 0) checkOutput("extra_out", 1, 0);
        else checkOutput("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input string prog, input logic [7:0] cell0);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) mem[i] = prog[i];
    mem[8'h80] = cell0;
    exp_q.delete();
    xfers  = 0;
    writes = 0;
  endtask

  task automatic startRun();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitHalt(input string tag);
    int n = 0;
    while (!bus.halted && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput({tag, "_halted"}, bus.halted, 1);
    checkOutput({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] v;
    int n;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;

    // Test 1: reset values, output timing, single transfer
    applyStimulus("+++.", 8'h00);
    exp_q.push_back(8'h03);
    startRun();
    checkOutput("rst_instptr", bus.instptr, 8'h00);
    checkOutput("rst_dataptr", bus.dataptr, 8'h80);
    checkOutput("rst_memwrite", bus.memwrite, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_halted", bus.halted, 0);
    checkOutput("rst_error", bus.error, 0);
    repeat (10) @(posedge clk);
    #1 checkOutput("t1_valid_c10", bus.out_valid, 0);
    @(posedge clk);
    #1 checkOutput("t1_valid_c11", bus.out_valid, 1);
    waitHalt("t1");
    checkOutput("t1_xfers", xfers, 1);
    checkOutput("t1_error", bus.error, 0);

    // Test 2: output backpressure
    applyStimulus("+++.", 8'h00);
    exp_q.push_back(8'h03);
    bus.out_ready = 1'b0;
    startRun();
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput("t2_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 checkOutput("t2_hold_valid", bus.out_valid, 1);
      checkOutput("t2_hold_data", bus.out_data, 8'h03);
      checkOutput("t2_hold_ip", bus.instptr, 8'h03);
    end
    bus.out_ready = 1'b1;
    waitHalt("t2");
    checkOutput("t2_xfers", xfers, 1);

    // Test 3: delayed input byte
    applyStimulus(",+.", 8'h00);
    exp_q.push_back(8'h42);
    startRun();
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput("t3_in_ready", bus.in_ready, 1);
    repeat (5) begin
      @(posedge clk);
      #1 checkOutput("t3_in_ready_hold", bus.in_ready, 1);
    end
    bus.in_data  = 8'h41;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checkOutput("t3_in_ready_drop", bus.in_ready, 0);
    waitHalt("t3");
    checkOutput("t3_writes", writes, 2);
    checkOutput("t3_xfers", xfers, 1);

    // Test 4: loop move and nested skip
    applyStimulus("++[>+<-]>.", 8'h00);
    exp_q.push_back(8'h02);
    startRun();
    waitHalt("t4a");
    checkOutput("t4a_cell0", mem[8'h80], 8'h00);
    checkOutput("t4a_cell1", mem[8'h81], 8'h02);
    checkOutput("t4a_error", bus.error, 0);

    applyStimulus("[[+]].", 8'h00);
    exp_q.push_back(8'h00);
    startRun();
    waitHalt("t4b");
    checkOutput("t4b_error", bus.error, 0);
    checkOutput("t4b_writes", writes, 0);
    checkOutput("t4b_xfers", xfers, 1);

    // Test 5: cell and pointer wrap
    applyStimulus("-<.", 8'h00);
    mem[8'h7F] = 8'h5A;
    exp_q.push_back(8'h5A);
    startRun();
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput("t5_dataptr", bus.dataptr, 8'h7F);
    waitHalt("t5");
    checkOutput("t5_cell0", mem[8'h80], 8'hFF);
    checkOutput("t5_writes", writes, 1);

    // Random cell values echoed straight out
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom_range(0, 255));
      applyStimulus(".", v);
      exp_q.push_back(v);
      startRun();
      waitHalt("rnd");
    end

    // Test 6: unmatched bracket, then reset aborting a scan and a write
    applyStimulus("[+", 8'h00);
    startRun();
    waitHalt("t6a");
    checkOutput("t6a_error", bus.error, 1);
    checkOutput("t6a_xfers", xfers, 0);

    applyStimulus("[", 8'h00);
    for (int i = 1; i <= 100; i++) mem[i] = 8'h2B;
    startRun();
    repeat (3) @(posedge clk);
    #1 checkOutput("t6b_scan_ip", bus.instptr, 8'h01);
    reset = 1'b1;
    @(posedge clk);
    #1 checkOutput("t6b_rst_ip", bus.instptr, 8'h00);
    checkOutput("t6b_rst_memwrite", bus.memwrite, 0);
    checkOutput("t6b_rst_halted", bus.halted, 0);

    applyStimulus("+", 8'h00);
    startRun();
    repeat (2) @(posedge clk);
    #1 checkOutput("t6c_write_pending", bus.memwrite, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 checkOutput("t6c_rst_memwrite", bus.memwrite, 0);
    checkOutput("t6c_rst_ip", bus.instptr, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
